otbn_mod_adder_pipe: RTL and testbench



---
 rtl/otbn_mod_adder_pipe.sv | 155 +++++++++++++++
 tb/tb_otbn_mod_adder_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otbn_mod_adder_pipe.sv
// Two-stage valid/ready modular adder: res = (op0 + op1) mod q over a burst of len elements.
// Defining OTBN_MODADD_RANGE_CHECK_EN adds a sticky operand range error flag on err_o.
module otbn_mod_adder_pipe #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [CNT_WIDTH-1:0]  len_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] op0_i,
   input  logic [DATA_WIDTH-1:0] op1_i,
   input  logic [DATA_WIDTH-1:0] q_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] res_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] in_cnt_q, in_cnt_d;
   logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic                 done_q, done_d;

   logic                  s1_valid_q;
   logic [DATA_WIDTH:0]   s1_sum_q;
   logic [DATA_WIDTH-1:0] s1_mod_q;
   logic                  s2_valid_q;
   logic [DATA_WIDTH-1:0] s2_res_q;

   logic                  s2_adv, accept, out_hs;
   logic [DATA_WIDTH:0]   sum_in;
   logic [DATA_WIDTH-1:0] red_diff, res_next;

   assign s2_adv  = s1_valid_q && (!s2_valid_q || ready_i);
   assign ready_o = (state_q == StRun) && (!s1_valid_q || s2_adv);
   assign accept  = valid_i && ready_o;
   assign out_hs  = s2_valid_q && ready_i;

   // Carry bit of the sum is kept so moduli near 2^DATA_WIDTH reduce correctly.
   assign sum_in   = {1'b0, op0_i} + {1'b0, op1_i};
   assign red_diff = s1_sum_q[DATA_WIDTH-1:0] - s1_mod_q;
   assign res_next = (s1_sum_q >= {1'b0, s1_mod_q}) ? red_diff : s1_sum_q[DATA_WIDTH-1:0];

   assign busy_o  = (state_q != StIdle);
   assign done_o  = done_q;
   assign valid_o = s2_valid_q;
   assign res_o   = s2_res_q;

   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (len_i != '0) begin
                  state_d   = StRun;
                  in_cnt_d  = len_i;
                  out_cnt_d = len_i;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StRun: begin
            if (accept) begin
               in_cnt_d = in_cnt_q - CntOne;
               if (in_cnt_q == CntOne) state_d = StDrain;
            end
            if (out_hs) out_cnt_d = out_cnt_q - CntOne;
         end
         StDrain: begin
            if (out_hs) begin
               out_cnt_d = out_cnt_q - CntOne;
               if (out_cnt_q == CntOne) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         done_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_sum_q   <= '0;
         s1_mod_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
      end else begin
         state_q   <= state_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         done_q    <= done_d;
         if (accept) begin
            s1_valid_q <= 1'b1;
            s1_sum_q   <= sum_in;
            s1_mod_q   <= q_i;
         end else if (s2_adv) begin
            s1_valid_q <= 1'b0;
         end
         if (s2_adv) begin
            s2_valid_q <= 1'b1;
            s2_res_q   <= res_next;
         end else if (out_hs) begin
            s2_valid_q <= 1'b0;
         end
      end
   end

`ifdef OTBN_MODADD_RANGE_CHECK_EN
   logic s1_err_q, s2_err_q, err_q;
   logic start_acc;

   assign start_acc = (state_q == StIdle) && start_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_err_q <= 1'b0;
         s2_err_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept) s1_err_q <= (op0_i >= q_i) || (op1_i >= q_i);
         if (s2_adv) s2_err_q <= s1_err_q;
         // Sticky until the next burst starts; raised only when the bad element leaves.
         if (start_acc) begin
            err_q <= 1'b0;
         end else if (out_hs && s2_err_q) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_otbn_mod_adder_pipe.sv
// Directed bench for otbn_mod_adder_pipe with a result scoreboard and output monitor.
module tb_otbn_mod_adder_pipe;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;
`ifdef OTBN_MODADD_RANGE_CHECK_EN
   localparam bit RangeChk = 1'b1;
`else
   localparam bit RangeChk = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_i, start_i, valid_i, ready_i;
   logic          busy_o, done_o, ready_o, valid_o, err_o;
   logic [CW-1:0] len_i;
   logic [DW-1:0] op0_i, op1_i, q_i, res_o;

   typedef struct packed {
      logic [DW-1:0] res;
      logic          flag;
   } exp_t;

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            inflight = 0;
   int            rdy_mode = 0;
   int            done_cnt = 0;
   int            exp_done = 0;
   int            last_hs_cyc = -1;
   int            first_acc_cyc = -1;
   int            first_vld_cyc = -1;
   logic          mon_en = 1'b0;
   logic          err_exp = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_res = '0;
   logic [3:0]    rdy_pat = 4'b1001;

   otbn_mod_adder_pipe #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst_i),
      .start_i(start_i),
      .len_i  (len_i),
      .busy_o (busy_o),
      .done_o (done_o),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .op0_i  (op0_i),
      .op1_i  (op1_i),
      .q_i    (q_i),
      .valid_o(valid_o),
      .ready_i(ready_i),
      .res_o  (res_o),
      .err_o  (err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic timeout(input string tag);
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed=timeout expected=event", tag);
   endtask

   function automatic logic [DW-1:0] model(input logic [DW-1:0] a, b, q);
      longint unsigned s;
      s = longint'(a) + longint'(b);
      if (s >= longint'(q)) s = s - longint'(q);
      return s[DW-1:0];
   endfunction

   // Ready pattern source: 0 = always ready, 1 = repeating 1-0-0-1, otherwise stalled.
   initial begin
      int ph;
      ph = 0;
      ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: ready_i = 1'b1;
            1: begin
               ready_i = rdy_pat[ph];
               ph = (ph + 1) % 4;
            end
            default: ready_i = 1'b0;
         endcase
      end
   end

   // Output monitor: scoreboard pops, stall stability, backpressure and err_o tracking.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("err_o", DW'(err_o), DW'(err_exp));
         if (rst_i) begin
            sb.delete();
            inflight = 0;
            err_exp = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("hold_valid", DW'(valid_o), DW'(1));
               chk("hold_res", res_o, prev_res);
            end
            if (inflight >= 2 && !ready_i) chk("ready_full", DW'(ready_o), DW'(0));
            if (valid_i && ready_o) begin
               inflight++;
               if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (valid_o && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (valid_o && ready_i) begin
               if (sb.size() == 0) begin
                  timeout("spurious_out");
               end else begin
                  e = sb.pop_front();
                  chk("res", res_o, e.res);
                  if (e.flag) err_exp = 1'b1;
               end
               inflight--;
               last_hs_cyc = cyc;
            end
            if (done_o) done_cnt++;
            prev_stall = valid_o && !ready_i;
            prev_res = res_o;
         end
      end
   end

   task automatic start_burst(input int n);
      @(posedge clk);
      #1;
      start_i = 1'b1;
      len_i = CW'(n);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      err_exp = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] a, b, q);
      exp_t e;
      valid_i = 1'b1;
      op0_i = a;
      op1_i = b;
      q_i = q;
      e.res = model(a, b, q);
      e.flag = RangeChk && ((a >= q) || (b >= q));
      sb.push_back(e);
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (ready_o) begin
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            return;
         end
      end
      timeout("send");
      valid_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (done_o) begin
            exp_done++;
            chk({tag, "_done_lat"}, DW'(cyc), DW'(last_hs_cyc + 1));
            chk({tag, "_busy_idle"}, DW'(busy_o), DW'(0));
            @(negedge clk);
            chk({tag, "_done_pulse"}, DW'(done_o), DW'(0));
            return;
         end
      end
      timeout({tag, "_done"});
   endtask

   initial begin
      rst_i = 1'b1;
      start_i = 1'b0;
      len_i = '0;
      valid_i = 1'b0;
      op0_i = '0;
      op1_i = '0;
      q_i = 32'd1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", DW'(busy_o), DW'(0));
      chk("rst_done", DW'(done_o), DW'(0));
      chk("rst_ready", DW'(ready_o), DW'(0));
      chk("rst_valid", DW'(valid_o), DW'(0));
      chk("rst_res", res_o, DW'(0));
      chk("rst_err", DW'(err_o), DW'(0));
      mon_en = 1'b1;
      rst_i = 1'b0;

      // Kyber modulus, boundary pairs, full throughput.
      start_burst(4);
      chk("t1_busy", DW'(busy_o), DW'(1));
      send(32'd1, 32'd2, 32'd3329);
      send(32'd3328, 32'd1, 32'd3329);
      send(32'd3328, 32'd3328, 32'd3329);
      send(32'd0, 32'd0, 32'd3329);
      wait_done("t1");
      chk("t1_latency", DW'(first_vld_cyc), DW'(first_acc_cyc + 2));
      chk("t1_back2back", DW'(last_hs_cyc), DW'(first_vld_cyc + 3));

      // Carry retention with the largest modulus.
      start_burst(1);
      send(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF);
      wait_done("t2");

      // Dilithium modulus under 1-0-0-1 backpressure.
      rdy_mode = 1;
      start_burst(6);
      for (int i = 0; i < 6; i++) send(DW'($urandom % 8380417), DW'($urandom % 8380417), 32'd8380417);
      wait_done("t3");
      rdy_mode = 0;

      // Zero-length burst.
      start_burst(0);
      @(negedge clk);
      chk("t4_done", DW'(done_o), DW'(1));
      chk("t4_busy", DW'(busy_o), DW'(0));
      chk("t4_ready", DW'(ready_o), DW'(0));
      exp_done++;
      @(negedge clk);
      chk("t4_done_pulse", DW'(done_o), DW'(0));
      chk("t4_ready2", DW'(ready_o), DW'(0));

      // Reset with two elements in flight.
      rdy_mode = 2;
      start_burst(5);
      send(32'd10, 32'd20, 32'd3329);
      send(32'd30, 32'd40, 32'd3329);
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_busy", DW'(busy_o), DW'(0));
      chk("t5_done", DW'(done_o), DW'(0));
      chk("t5_ready", DW'(ready_o), DW'(0));
      chk("t5_valid", DW'(valid_o), DW'(0));
      chk("t5_res", res_o, DW'(0));
      chk("t5_err", DW'(err_o), DW'(0));
      rst_i = 1'b0;
      rdy_mode = 0;
      repeat (3) begin
         @(negedge clk);
         chk("t5_no_done", DW'(done_o), DW'(0));
      end
      start_burst(3);
      send(32'd100, 32'd3300, 32'd3329);
      send(32'd2000, 32'd1329, 32'd3329);
      send(32'd7, 32'd8, 32'd3329);
      wait_done("t5b");

      // Out-of-range operand: sticky err_o only with the range check built in.
      start_burst(2);
      send(32'd3329, 32'd0, 32'd3329);
      send(32'd1, 32'd1, 32'd3329);
      wait_done("t6");
      chk("t6_err_sticky", DW'(err_o), DW'(RangeChk));
      start_burst(1);
      chk("t6_err_clr", DW'(err_o), DW'(0));
      send(32'd5, 32'd6, 32'd3329);
      wait_done("t6b");

      chk("sb_empty", DW'(sb.size()), DW'(0));
      chk("done_count", DW'(done_cnt), DW'(exp_done));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
